ac_seq: RTL
===========

AC_SEQ -- requirements
Module: ac_seq

Interface
REQ-001 Parameter: DATA_W, 8, width of operand, Z bus and AC feedback (signed two's complement).
REQ-002 Parameter: CNT_W, 4, width of repeat-count field.
REQ-003 One clock; reset is synchronous and active-low.
REQ-004 clk  input  1  clock; all state changes on rising edge.
REQ-005 rst_n  input  1  synchronous active-low reset.
REQ-006 op_valid  input  1  requester presents a command.
REQ-007 op_ready  output  1  sequencer can accept a command.
REQ-008 op_code  input  2  00 LOAD, 01 ADD, 10 SUB, 11 CLR.
REQ-009 operand  input  DATA_W  signed operand.
REQ-010 op_count  input  CNT_W  repeat count; command executes op_count+1 times.
REQ-011 ac_in  input  DATA_W  current AC register value, fed back from the accumulator.
REQ-012 z_out  output  DATA_W  registered value driven to accumulator Z input.
REQ-013 load_ac  output  1  accumulator load strobe, connects to LOAD_AC.
REQ-014 done  output  1  one-cycle pulse when a command completes.
REQ-015 ovf  output  1  sticky signed-overflow flag for the current/last command.
REQ-016 busy  output  1  high in every state except IDLE.

Function
REQ-017 FSM states: IDLE, CALC, WRITE, DONE; state register and all outputs registered.
REQ-018 IDLE: op_ready=1; op_valid=1 at an edge captures op_code, operand, op_count into internal registers, clears ovf, goes to CALC.
REQ-019 op_ready SHALL be 0 in CALC, WRITE, DONE; op_valid there is ignored, not queued.
REQ-020 CALC: one cycle; z_out loaded with LOAD: operand; ADD: ac_in+operand; SUB: ac_in-operand; CLR: 0; goes to WRITE.
REQ-021 ADD/SUB results wrap modulo 2^DATA_W; ovf set when operand signs and result sign indicate signed overflow; ovf never cleared by a later in-range iteration.
REQ-022 WRITE: load_ac=1 for exactly this cycle, z_out held stable; load_ac is 0 in every other state.
REQ-023 WRITE exit: remaining count 0 -> DONE; else decrement count, -> CALC (ac_in then reflects the value just loaded).
REQ-024 DONE: done=1 for one cycle, z_out held, -> IDLE.
REQ-025 Latency: accept edge to done pulse = 2*(op_count+1)+1 cycles; op_count=0 gives done 3 cycles after accept.
REQ-026 op_count all ones executes 2^CNT_W iterations; counter never wraps below zero.
REQ-027 LOAD and CLR with op_count>0 repeat identically; ovf stays 0.
REQ-028 busy=1 in CALC, WRITE, DONE; busy and op_ready are always complementary.

Reset
REQ-029 rst_n=0 at a rising edge forces IDLE, z_out=0, load_ac=0, done=0, ovf=0, internal count=0, captured op cleared.
REQ-030 Reset mid-command aborts immediately; no further load_ac or done pulse for that command.
REQ-031 rst_n asserted overrides op_valid in the same cycle; no command accepted.
REQ-032 First command accepted on the first edge with rst_n=1 and op_valid=1.

Verification
REQ-033 Reset, LOAD operand=0x25 count=0 -> one load_ac pulse with z_out=0x25, done 3 cycles after accept, ovf=0.
REQ-034 ac_in model=0x10, ADD operand=0x03 count=3 -> four load_ac pulses, z_out 0x13,0x16,0x19,0x1C, done on cycle 9, ovf=0.
REQ-035 ac=0x7F, ADD operand=0x01 count=0 -> z_out=0x80, ovf=1; next SUB 0x01 from 0x80 -> z_out=0x7F, ovf=1 (set, sticky within command).
REQ-036 ac=0x05, SUB operand=0x05 count=1 -> z_out 0x00 then 0xFB, ovf=0; op_valid held high throughout -> second command accepted only after return to IDLE.
REQ-037 ADD operand=0x01 count=15, rst_n=0 during third WRITE -> outputs zero next cycle, no done, op_ready=1 after release.
REQ-038 CLR count=2 with ac=0x5A -> three load_ac pulses, z_out=0x00, done, ovf=0.

Source files
------------

// File: rtl/ac_seq.sv
// Repeat-command sequencer that drives an external accumulator through its Z bus and
// LOAD_AC strobe, computing each iteration from the fed-back AC value.
module ac_seq #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CNT_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [1:0]        op_code,
  input  logic [DATA_W-1:0] operand,
  input  logic [CNT_W-1:0]  op_count,
  input  logic [DATA_W-1:0] ac_in,
  output logic [DATA_W-1:0] z_out,
  output logic              load_ac,
  output logic              done,
  output logic              ovf,
  output logic              busy
);

  localparam int unsigned Msb = DATA_W - 1;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StCalc  = 2'b01,
    StWrite = 2'b10,
    StDone  = 2'b11
  } state_e;

  typedef enum logic [1:0] {
    OpLoad = 2'b00,
    OpAdd  = 2'b01,
    OpSub  = 2'b10,
    OpClr  = 2'b11
  } op_e;

  state_e              state_q;
  op_e                 code_q;
  logic [DATA_W-1:0]   operand_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [DATA_W-1:0]   z_q;
  logic                load_q;
  logic                done_q;
  logic                ovf_q;
  logic                ready_q;
  logic                busy_q;

  logic [DATA_W-1:0]   add_res;
  logic [DATA_W-1:0]   sub_res;
  logic                add_ovf;
  logic                sub_ovf;
  logic [DATA_W-1:0]   calc_z;
  logic                calc_ovf;

  // Signed overflow: operands of like sign (ADD) or unlike sign (SUB) whose result
  // sign differs from the AC sign.
  always_comb begin
    add_res  = ac_in + operand_q;
    sub_res  = ac_in - operand_q;
    add_ovf  = (ac_in[Msb] == operand_q[Msb]) && (add_res[Msb] != ac_in[Msb]);
    sub_ovf  = (ac_in[Msb] != operand_q[Msb]) && (sub_res[Msb] != ac_in[Msb]);
    calc_z   = '0;
    calc_ovf = 1'b0;
    unique case (code_q)
      OpLoad: calc_z = operand_q;
      OpAdd: begin
        calc_z   = add_res;
        calc_ovf = add_ovf;
      end
      OpSub: begin
        calc_z   = sub_res;
        calc_ovf = sub_ovf;
      end
      OpClr: calc_z = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      code_q    <= OpLoad;
      operand_q <= '0;
      cnt_q     <= '0;
      z_q       <= '0;
      load_q    <= 1'b0;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      load_q <= 1'b0;
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (op_valid) begin
            code_q    <= op_e'(op_code);
            operand_q <= operand;
            cnt_q     <= op_count;
            ovf_q     <= 1'b0;
            ready_q   <= 1'b0;
            busy_q    <= 1'b1;
            state_q   <= StCalc;
          end
        end
        StCalc: begin
          z_q     <= calc_z;
          ovf_q   <= ovf_q | calc_ovf;
          load_q  <= 1'b1;
          state_q <= StWrite;
        end
        StWrite: begin
          if (cnt_q == '0) begin
            done_q  <= 1'b1;
            state_q <= StDone;
          end else begin
            cnt_q   <= cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
            state_q <= StCalc;
          end
        end
        StDone: begin
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign z_out    = z_q;
  assign load_ac  = load_q;
  assign done     = done_q;
  assign ovf      = ovf_q;
  assign op_ready = ready_q;
  assign busy     = busy_q;

endmodule
